// File: rtl/funprof_pkg.sv
// Shared definitions for the function-profiler counter bank: snapshot stream
// FSM encoding, channel-index width helper and the default counter width.
package funprof_pkg;

    localparam int FUNPROF_DEFAULT_WIDTH = 32;

    typedef enum logic [0:0] {
        SNAP_IDLE   = 1'b0,
        SNAP_STREAM = 1'b1
    } snap_state_e;

    // A single-channel bank still carries a 1-bit channel index.
    function automatic int ch_width(input int num_ch);
        int w;
        w = $clog2(num_ch);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/funprof_chan_counter.sv
// One profiler counter channel: WIDTH-bit event count with sticky overflow,
// wrap or saturate behaviour and an atomic clear tied to snapshot capture.
module funprof_chan_counter
    import funprof_pkg::*;
#(
    parameter int WIDTH = FUNPROF_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             freeze,
    input  logic             snap_clear,
    input  logic             saturate,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             inc_s;

    assign inc_s = enable && !freeze && !clear;

    // Next count/ovf: clear wins, then snapshot restart (keeping this edge's event), then counting.
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (clear) begin
            count_nxt_s = CNT_ZERO;
            ovf_nxt_s   = 1'b0;
        end else if (snap_clear) begin
            count_nxt_s = inc_s ? CNT_ONE : CNT_ZERO;
            ovf_nxt_s   = 1'b0;
        end else if (inc_s) begin
            if (count_r == CNT_MAX) begin
                count_nxt_s = saturate ? CNT_MAX : CNT_ZERO;
                ovf_nxt_s   = 1'b1;
            end else begin
                count_nxt_s = count_r + CNT_ONE;
                ovf_nxt_s   = ovf_r;
            end
        end else begin
            count_nxt_s = count_r;
            ovf_nxt_s   = ovf_r;
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign count = count_r;
    assign ovf   = ovf_r;

endmodule

// File: rtl/funprof_counter_bank.sv
// Multi-channel profiler counter bank with atomic snapshot streamed over valid/ready.
// Optional overflow interrupt output enabled by defining FUNPROF_OVF_IRQ_EN.
module funprof_counter_bank
    import funprof_pkg::*;
#(
    parameter int  NUM_CH        = 4,
    parameter int  WIDTH         = FUNPROF_DEFAULT_WIDTH,
    parameter bit  SATURATE      = 1'b0,
    parameter bit  CLEAR_ON_SNAP = 1'b0,
    localparam int CH_W          = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] clear,
    input  logic              freeze,
    input  logic              snap_req,
    output logic              snap_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_ovf,
    output logic              out_last,
`ifdef FUNPROF_OVF_IRQ_EN
    output logic              irq,
`endif
    output logic [NUM_CH-1:0] ovf
);

    localparam logic [CH_W-1:0]  FIRST_CH = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 32'sd1);
    localparam logic [CH_W-1:0]  CH_STEP  = CH_W'(32'd1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    snap_state_e                   state_r;
    snap_state_e                   state_nxt_s;
    logic                          capture_s;
    logic                          xfer_s;
    logic                          snap_clear_s;
    logic [NUM_CH-1:0][WIDTH-1:0]  count_s;
    logic [NUM_CH-1:0]             ovf_s;
    logic [NUM_CH-1:0][WIDTH-1:0]  shadow_r;
    logic [NUM_CH-1:0]             shadow_ovf_r;
    logic [CH_W-1:0]               idx_r;
    logic [CH_W-1:0]               idx_nxt_s;
    logic [WIDTH-1:0]              data_r;
    logic                          data_ovf_r;
    logic                          last_r;

    assign snap_clear_s = CLEAR_ON_SNAP && capture_s;
    assign idx_nxt_s    = idx_r + CH_STEP;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            funprof_chan_counter #(
                .WIDTH(WIDTH)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .enable    (enable[g]),
                .clear     (clear[g]),
                .freeze    (freeze),
                .snap_clear(snap_clear_s),
                .saturate  (SATURATE),
                .count     (count_s[g]),
                .ovf       (ovf_s[g])
            );
        end
    endgenerate

    // Snapshot FSM next state; requests arriving while streaming are dropped.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        xfer_s      = 1'b0;
        case (state_r)
            SNAP_IDLE: begin
                if (snap_req) begin
                    capture_s   = 1'b1;
                    state_nxt_s = SNAP_STREAM;
                end else begin
                    state_nxt_s = SNAP_IDLE;
                end
            end
            SNAP_STREAM: begin
                if (out_ready) begin
                    xfer_s      = 1'b1;
                    state_nxt_s = last_r ? SNAP_IDLE : SNAP_STREAM;
                end else begin
                    state_nxt_s = SNAP_STREAM;
                end
            end
            default: begin
                state_nxt_s = SNAP_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= SNAP_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shadow copy of all channels, taken from the pre-edge counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_r     <= '{default: CNT_ZERO};
            shadow_ovf_r <= {NUM_CH{1'b0}};
        end else if (capture_s) begin
            shadow_r     <= count_s;
            shadow_ovf_r <= ovf_s;
        end else begin
            shadow_r     <= shadow_r;
            shadow_ovf_r <= shadow_ovf_r;
        end
    end

    // Beat registers: beat 0 loads straight from the live counts, later beats from the shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r      <= FIRST_CH;
            data_r     <= CNT_ZERO;
            data_ovf_r <= 1'b0;
            last_r     <= 1'b0;
        end else if (capture_s) begin
            idx_r      <= FIRST_CH;
            data_r     <= count_s[0];
            data_ovf_r <= ovf_s[0];
            last_r     <= (NUM_CH == 32'sd1);
        end else if (xfer_s && last_r) begin
            idx_r      <= FIRST_CH;
            data_r     <= CNT_ZERO;
            data_ovf_r <= 1'b0;
            last_r     <= 1'b0;
        end else if (xfer_s) begin
            idx_r      <= idx_nxt_s;
            data_r     <= shadow_r[idx_nxt_s];
            data_ovf_r <= shadow_ovf_r[idx_nxt_s];
            last_r     <= (idx_nxt_s == LAST_CH);
        end else begin
            idx_r      <= idx_r;
            data_r     <= data_r;
            data_ovf_r <= data_ovf_r;
            last_r     <= last_r;
        end
    end

`ifdef FUNPROF_OVF_IRQ_EN
    logic irq_r;

    // Interrupt follows the OR of the live overflow flags by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |ovf_s;
        end
    end

    assign irq = irq_r;
`endif

    assign snap_busy = (state_r == SNAP_STREAM);
    assign out_valid = (state_r == SNAP_STREAM);
    assign out_data  = data_r;
    assign out_ch    = idx_r;
    assign out_ovf   = data_ovf_r;
    assign out_last  = last_r;
    assign ovf       = ovf_s;

endmodule

// File: tb/tb_funprof_counter_bank.sv
// Directed bench for funprof_counter_bank: an 8-bit wrap bank and an 8-bit
// saturate/clear-on-snapshot bank share stimulus and are checked against a queue model.
module tb_funprof_counter_bank;

    logic       clk;
    logic       reset;
    logic [3:0] enable;
    logic [3:0] clear;
    logic       freeze;
    logic       snap_req;
    logic       out_ready;

    logic       o_busy  [2];
    logic       o_valid [2];
    logic [7:0] o_data  [2];
    logic [1:0] o_ch    [2];
    logic       o_ovf   [2];
    logic       o_last  [2];
    logic [3:0] o_ovfv  [2];
`ifdef FUNPROF_OVF_IRQ_EN
    logic       o_irq   [2];
    logic       m_irq   [2];
`endif

    typedef struct packed {
        logic [1:0]      ch;
        logic [1:0][7:0] data;
        logic [1:0]      ovf;
    } beat_t;

    int         m_cnt [2][4];
    logic [3:0] m_ovf [2];
    beat_t      mq[$];

    int n_pass;
    int n_total;

    funprof_counter_bank #(
        .NUM_CH(4), .WIDTH(8), .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b0)
    ) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .freeze(freeze),
        .snap_req(snap_req), .snap_busy(o_busy[0]), .out_valid(o_valid[0]),
        .out_ready(out_ready), .out_data(o_data[0]), .out_ch(o_ch[0]),
        .out_ovf(o_ovf[0]), .out_last(o_last[0]),
`ifdef FUNPROF_OVF_IRQ_EN
        .irq(o_irq[0]),
`endif
        .ovf(o_ovfv[0])
    );

    funprof_counter_bank #(
        .NUM_CH(4), .WIDTH(8), .SATURATE(1'b1), .CLEAR_ON_SNAP(1'b1)
    ) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .freeze(freeze),
        .snap_req(snap_req), .snap_busy(o_busy[1]), .out_valid(o_valid[1]),
        .out_ready(out_ready), .out_data(o_data[1]), .out_ch(o_ch[1]),
        .out_ovf(o_ovf[1]), .out_last(o_last[1]),
`ifdef FUNPROF_OVF_IRQ_EN
        .irq(o_irq[1]),
`endif
        .ovf(o_ovfv[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    // Bank 0 wraps and keeps counts on snapshot; bank 1 saturates and restarts on snapshot.
    task automatic model_step();
        bit    cap;
        bit    xfer;
        bit    inc;
        beat_t b;
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) m_cnt[d][i] = 0;
                m_ovf[d] = 4'b0000;
`ifdef FUNPROF_OVF_IRQ_EN
                m_irq[d] = 1'b0;
`endif
            end
            mq.delete();
            return;
        end
        cap  = (mq.size() == 0) && snap_req;
        xfer = (mq.size() != 0) && out_ready;
`ifdef FUNPROF_OVF_IRQ_EN
        for (int d = 0; d < 2; d++) m_irq[d] = (m_ovf[d] != 4'b0000);
`endif
        if (xfer) void'(mq.pop_front());
        if (cap) begin
            for (int i = 0; i < 4; i++) begin
                b.ch = 2'(i);
                for (int d = 0; d < 2; d++) begin
                    b.data[d] = 8'(m_cnt[d][i]);
                    b.ovf[d]  = m_ovf[d][i];
                end
                mq.push_back(b);
            end
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                inc = enable[i] && !freeze && !clear[i];
                if (clear[i]) begin
                    m_cnt[d][i] = 0;
                    m_ovf[d][i] = 1'b0;
                end else if (cap && d == 1) begin
                    m_cnt[d][i] = inc ? 1 : 0;
                    m_ovf[d][i] = 1'b0;
                end else if (inc && m_cnt[d][i] == 255) begin
                    m_ovf[d][i] = 1'b1;
                    if (d == 0) m_cnt[d][i] = 0;
                end else if (inc) begin
                    m_cnt[d][i] = m_cnt[d][i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("out_valid", d, 32'(o_valid[d]), 32'(mq.size() != 0));
            chk("snap_busy", d, 32'(o_busy[d]), 32'(mq.size() != 0));
            chk("ovf", d, 32'(o_ovfv[d]), 32'(m_ovf[d]));
`ifdef FUNPROF_OVF_IRQ_EN
            chk("irq", d, 32'(o_irq[d]), 32'(m_irq[d]));
`endif
            if (mq.size() != 0) begin
                chk("out_ch", d, 32'(o_ch[d]), 32'(mq[0].ch));
                chk("out_data", d, 32'(o_data[d]), 32'(mq[0].data[d]));
                chk("out_ovf", d, 32'(o_ovf[d]), 32'(mq[0].ovf[d]));
                chk("out_last", d, 32'(o_last[d]), 32'(mq[0].ch == 2'd3));
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Capture (with en_cap on the capture edge) and drain with out_ready high; d packs ch3..ch0 bytes.
    task automatic snap_expect(input logic [3:0] en_cap, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [3:0] v0, input logic [3:0] v1);
        enable   = en_cap;
        clear    = 4'b0000;
        snap_req = 1'b1;
        cycle();
        enable    = 4'b0000;
        snap_req  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("lit_ch", 0, 32'(o_ch[0]), 32'(c));
            chk("lit_data", 0, 32'(o_data[0]), 32'(d0[c*8 +: 8]));
            chk("lit_data", 1, 32'(o_data[1]), 32'(d1[c*8 +: 8]));
            chk("lit_ovf", 0, 32'(o_ovf[0]), 32'(v0[c]));
            chk("lit_ovf", 1, 32'(o_ovf[1]), 32'(v1[c]));
            chk("lit_last", 0, 32'(o_last[0]), 32'(c == 3));
            cycle();
        end
        chk("lit_busy_end", 0, 32'(o_busy[0]), 32'd0);
        chk("lit_busy_end", 1, 32'(o_busy[1]), 32'd0);
    endtask

    initial begin
        logic [3:0] pat;
        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        enable    = 4'b0000;
        clear     = 4'b0000;
        freeze    = 1'b0;
        snap_req  = 1'b0;
        out_ready = 1'b0;
        pat       = 4'b1001;
        cycle();
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", d, 32'(o_valid[d]), 32'd0);
            chk("rst_busy", d, 32'(o_busy[d]), 32'd0);
            chk("rst_ch", d, 32'(o_ch[d]), 32'd0);
            chk("rst_last", d, 32'(o_last[d]), 32'd0);
            chk("rst_ovf", d, 32'(o_ovfv[d]), 32'd0);
        end
        reset = 1'b0;

        // Ten counts on ch0; freeze and clear-over-enable must not add any.
        enable = 4'b0001;
        repeat (10) cycle();
        freeze = 1'b1;
        repeat (2) cycle();
        freeze = 1'b0;
        enable = 4'b0010;
        clear  = 4'b0010;
        cycle();
        snap_expect(4'b0000, 32'h0000_000A, 32'h0000_000A, 4'b0000, 4'b0000);

        // 257 events on ch1: wrap lands on 1, saturate holds 255; both flag overflow.
        enable = 4'b0010;
        repeat (257) cycle();
        snap_expect(4'b0000, 32'h0000_010A, 32'h0000_FF00, 4'b0010, 4'b0010);
        chk("lit_ovf_sticky", 0, 32'(o_ovfv[0]), 32'h2);
        chk("lit_ovf_snapclr", 1, 32'(o_ovfv[1]), 32'h0);

        // Increment on the capture edge goes to the live count, not the shadow.
        clear = 4'b1111;
        cycle();
        clear  = 4'b0000;
        enable = 4'b0001;
        repeat (5) cycle();
        snap_expect(4'b0001, 32'h0000_0005, 32'h0000_0005, 4'b0000, 4'b0000);
        snap_expect(4'b0000, 32'h0000_0006, 32'h0000_0001, 4'b0000, 4'b0000);

        // Back-pressure pattern 1,0,0,1 with counting still running on ch3.
        enable    = 4'b1000;
        snap_req  = 1'b1;
        out_ready = 1'b0;
        cycle();
        snap_req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            out_ready = pat[k % 4];
            cycle();
        end
        enable = 4'b0000;
        chk("lit_stall_done", 0, 32'(o_busy[0]), 32'd0);

        // snap_req held through the whole stream, including the final transfer.
        snap_req  = 1'b1;
        out_ready = 1'b1;
        cycle();
        repeat (4) cycle();
        snap_req = 1'b0;
        chk("lit_req_ignored", 0, 32'(o_valid[0]), 32'd0);
        chk("lit_req_ignored", 1, 32'(o_valid[1]), 32'd0);

        // Reset in the middle of a stream.
        enable = 4'b1111;
        repeat (3) cycle();
        enable   = 4'b0000;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("lit_rst_mid", 0, 32'(o_valid[0]), 32'd0);
        chk("lit_rst_mid", 1, 32'(o_valid[1]), 32'd0);
        snap_expect(4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 4'b0000);

        // Overflow on ch2 after exactly 256 events, then clear it.
        enable = 4'b0100;
        repeat (255) cycle();
        chk("lit_no_ovf_yet", 0, 32'(o_ovfv[0]), 32'h0);
        chk("lit_no_ovf_yet", 1, 32'(o_ovfv[1]), 32'h0);
        cycle();
        enable = 4'b0000;
        chk("lit_ovf2", 0, 32'(o_ovfv[0]), 32'h4);
        chk("lit_ovf2", 1, 32'(o_ovfv[1]), 32'h4);
`ifdef FUNPROF_OVF_IRQ_EN
        chk("lit_irq_lag", 0, 32'(o_irq[0]), 32'd0);
`endif
        cycle();
`ifdef FUNPROF_OVF_IRQ_EN
        chk("lit_irq_rise", 0, 32'(o_irq[0]), 32'd1);
`endif
        clear = 4'b0100;
        cycle();
        clear = 4'b0000;
        chk("lit_ovf2_clr", 0, 32'(o_ovfv[0]), 32'h0);
`ifdef FUNPROF_OVF_IRQ_EN
        chk("lit_irq_hold", 0, 32'(o_irq[0]), 32'd1);
`endif
        cycle();
`ifdef FUNPROF_OVF_IRQ_EN
        chk("lit_irq_fall", 0, 32'(o_irq[0]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
